// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : Handshake and payload bundle between the decode stage, the
//                ID/EX pipeline register and the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int DATA_W   = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int RADDR_W  = 5,
    parameter int CNT_W    = 16
) ();
    // Upstream (decode) side
    logic                id_valid;
    logic                id_ready;
    logic [ALUOP_W-1:0]  id_aluop;
    logic [ALUSEL_W-1:0] id_alusel;
    logic [DATA_W-1:0]   id_reg1;
    logic [DATA_W-1:0]   id_reg2;
    logic [DATA_W-1:0]   id_pc;
    logic [RADDR_W-1:0]  id_wd;
    logic                id_wreg;

    // Pipeline control
    logic                flush;

    // Downstream (execute) side
    logic                ex_valid;
    logic                ex_ready;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [ALUSEL_W-1:0] ex_alusel;
    logic [DATA_W-1:0]   ex_reg1;
    logic [DATA_W-1:0]   ex_reg2;
    logic [DATA_W-1:0]   ex_pc;
    logic [RADDR_W-1:0]  ex_wd;
    logic                ex_wreg;

    // Back-pressure statistics
    logic [CNT_W-1:0]    stall_cnt;

    // Environment side: drives decode payload, flush and execute ready
    modport master (
        output id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_pc, id_wd, id_wreg,
        output flush, ex_ready,
        input  id_ready, ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_pc,
        input  ex_wd, ex_wreg, stall_cnt
    );

    // Pipeline register side
    modport slave (
        input  id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_pc, id_wd, id_wreg,
        input  flush, ex_ready,
        output id_ready, ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_pc,
        output ex_wd, ex_wreg, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with valid/ready handshake, flush
//                and a saturating back-pressure counter.
//                Build macro ID_EX_SKID_EN selects a two-entry skid buffer
//                with a registered id_ready; otherwise a single entry whose
//                id_ready is (!ex_valid || ex_ready).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W   = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int RADDR_W  = 5,
    parameter int CNT_W    = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    id_ex_stage_if.slave bus
);
    // One packed word carries the whole payload; wreg sits in bit 0
    localparam int c_PL_W = ALUOP_W + ALUSEL_W + 3 * DATA_W + RADDR_W + 1;

    logic [c_PL_W-1:0] w_in_pl;
    logic [c_PL_W-1:0] out_pl_q;
    logic [c_PL_W-1:0] out_pl_d;
    logic              w_held_wreg;
    logic              w_ex_valid;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    assign w_in_pl = {bus.id_aluop, bus.id_alusel, bus.id_reg1, bus.id_reg2,
                      bus.id_pc, bus.id_wd, bus.id_wreg};

    assign {bus.ex_aluop, bus.ex_alusel, bus.ex_reg1, bus.ex_reg2,
            bus.ex_pc, bus.ex_wd, w_held_wreg} = out_pl_q;

    // A stale entry must never look like a register write to execute
    assign bus.ex_wreg   = w_held_wreg & w_ex_valid;
    assign bus.ex_valid  = w_ex_valid;
    assign bus.stall_cnt = stall_cnt_q;
    assign w_pop         = w_ex_valid & bus.ex_ready;

`ifdef ID_EX_SKID_EN
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [c_PL_W-1:0] skid_pl_q;
    logic [c_PL_W-1:0] skid_pl_d;
    logic              id_ready_q;
    logic              id_ready_d;

    // id_ready comes straight from a flop, so ex_ready never reaches it
    assign bus.id_ready = id_ready_q;
    assign w_ex_valid   = (state_q != c_ST_EMPTY);
    assign w_push       = bus.id_valid & id_ready_q;

    // State register and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_EMPTY;
            id_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            id_ready_q <= id_ready_d;
        end
    end

    // Next-state: occupancy follows push/pop, flush empties everything
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = c_ST_EMPTY;
        end else begin
            case (state_q)
                c_ST_EMPTY: if (w_push)            state_d = c_ST_ONE;
                c_ST_ONE: begin
                    if (w_push && !w_pop)          state_d = c_ST_FULL;
                    else if (!w_push && w_pop)     state_d = c_ST_EMPTY;
                end
                c_ST_FULL:  if (w_pop)             state_d = c_ST_ONE;
                default:                           state_d = c_ST_EMPTY;
            endcase
        end
    end

    // Output/datapath: steer incoming word to output or skid slot, refill from skid
    always_comb begin
        out_pl_d   = out_pl_q;
        skid_pl_d  = skid_pl_q;
        id_ready_d = (state_d != c_ST_FULL);
        if (!bus.flush) begin
            case (state_q)
                c_ST_EMPTY: if (w_push) out_pl_d = w_in_pl;
                c_ST_ONE: begin
                    if (w_push && w_pop)   out_pl_d  = w_in_pl;
                    else if (w_push)       skid_pl_d = w_in_pl;
                end
                c_ST_FULL:  if (w_pop)  out_pl_d = skid_pl_q;
                default: ;
            endcase
        end
    end

    // Skid slot storage
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_pl_q <= '0;
        end else begin
            skid_pl_q <= skid_pl_d;
        end
    end
`else
    logic valid_q;
    logic valid_d;
    logic w_id_ready;

    assign w_ex_valid   = valid_q;
    assign w_id_ready   = !valid_q || bus.ex_ready;
    assign bus.id_ready = w_id_ready;
    assign w_push       = bus.id_valid & w_id_ready;

    // Single entry: load on push, drain on pop, flush drops both
    always_comb begin
        valid_d  = valid_q;
        out_pl_d = out_pl_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (w_push) begin
            valid_d  = 1'b1;
            out_pl_d = w_in_pl;
        end else if (w_pop) begin
            valid_d = 1'b0;
        end
    end

    // Entry-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end
`endif

    // Back-pressure counter: count stalled cycles, stick at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_ex_valid && !bus.ex_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Output payload and counter registers; reset presents a NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pl_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_pl_q    <= out_pl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/PC width.
REQ-002 SHALL have parameter ALUOP_W, default 8, ALU opcode width.
REQ-003 SHALL have parameter ALUSEL_W, default 3, result-select width.
REQ-004 SHALL have parameter RADDR_W, default 5, destination register address width.
REQ-005 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-006 Ports, in order: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-007 id_valid in 1 upstream entry valid; id_ready out 1 stage can accept.
REQ-008 id_aluop in ALUOP_W; id_alusel in ALUSEL_W; id_reg1, id_reg2, id_pc in DATA_W each; id_wd in RADDR_W; id_wreg in 1.
REQ-009 flush in 1 discard all held and incoming entries (branch/exception).
REQ-010 ex_valid out 1; ex_ready in 1 downstream accepts.
REQ-011 ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_pc, ex_wd, ex_wreg out, widths matching id_ counterparts.
REQ-012 stall_cnt out CNT_W, count of downstream back-pressure cycles.

Function
REQ-013 Upstream transfer SHALL occur on a rising clk edge with id_valid=1 and id_ready=1; downstream transfer on ex_valid=1 and ex_ready=1.
REQ-014 Entries SHALL leave in arrival order; no entry duplicated or lost except by flush/rst.
REQ-015 Payload SHALL be captured unmodified; latency from upstream transfer to ex_valid=1 SHALL be exactly 1 cycle when the stage is empty.
REQ-016 ex_wreg SHALL read 0 whenever ex_valid=0; other ex_ payload outputs SHALL hold their last value when ex_valid=0.
REQ-017 Outputs SHALL remain stable while ex_valid=1 and ex_ready=0.
REQ-018 flush=1 SHALL, at the next edge, set ex_valid=0, empty all storage, and drop any same-cycle upstream entry; flush SHALL override simultaneous transfers.
REQ-019 stall_cnt SHALL increment by 1 each cycle with ex_valid=1 and ex_ready=0, saturate at 2^CNT_W-1, never wrap, and clear only on rst.
REQ-020 Simultaneous upstream and downstream transfer in one cycle SHALL keep occupancy unchanged and sustain 1 entry/cycle.

Reset
REQ-021 With rst=1 at an edge: ex_valid=0, ex_aluop=0 (NOP op), ex_alusel=0 (NOP result), ex_reg1=ex_reg2=ex_pc=0, ex_wd=0 (NOP reg addr), ex_wreg=0, stall_cnt=0, storage empty.
REQ-022 rst SHALL override flush and all transfers; rst mid-stall SHALL discard held entries.
REQ-023 id_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-024 Macro ID_EX_SKID_EN defined: two-entry skid buffer, states EMPTY, ONE, FULL; id_ready SHALL be driven from a register (=state!=FULL), no combinational path from ex_ready.
REQ-025 Skid transitions: EMPTY->ONE on in; ONE->FULL on in without out; ONE->EMPTY on out without in; FULL->ONE on out; in+out in ONE stays ONE; flush -> EMPTY.
REQ-026 Macro undefined: single entry; id_ready SHALL equal (!ex_valid || ex_ready) combinationally; behaviour otherwise per REQ-013..REQ-020.

Verification
REQ-027 rst 2 cycles, then idle -> all ex_ outputs 0, ex_valid=0, id_ready=1, stall_cnt=0.
REQ-028 Stream 4 entries (reg1=0x11,0x22,0x33,0x44, wd=1..4, wreg=1) with ex_ready=1 -> each appears 1 cycle later, one per cycle, in order.
REQ-029 Entry reg1=0xA5A5A5A5, ex_ready=0 for 5 cycles, then 1 -> outputs stable for 5 cycles, stall_cnt=5; with ID_EX_SKID_EN a second entry is accepted, a third sees id_ready=0.
REQ-030 Stage FULL, flush=1 with id_valid=1 -> next cycle ex_valid=0, ex_wreg=0, id_ready=1; neither held nor incoming entry ever emerges.
REQ-031 CNT_W=4, ex_ready=0 with entry held for 20 cycles -> stall_cnt=15 and holds.
REQ-032 rst asserted while FULL and flush=1 -> next cycle all outputs at reset values, stall_cnt=0.
